ahblite_lcd_fetch: RTL and testbench
====================================

# ahblite_lcd_fetch

AHB-Lite bus master that reads a contiguous block of 32-bit words from system memory (frame buffer) and streams them to the LCD pixel path over a valid/ready interface. It is the initiator counterpart to the LCD register slave: software programs base address and word count, pulses start, and the block issues pipelined single-word read transfers, buffering returned data in a small FIFO so the bus never stalls on a slow pixel sink.

## Interface
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, ≥2
- HPROT_VAL, 4'b0011, constant driven on HPROT (data, privileged)

- HCLK  in  1  clock; all logic rising-edge
- HRESETn  in  1  asynchronous active-low reset
- HADDR  out  32  transfer address, word aligned
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  HPROT_VAL
- HWRITE  out  1  constant 0
- HWDATA  out  32  constant 0
- HREADY  in  1  bus ready
- HRDATA  in  32  read data
- HRESP  in  1  error response
- start  in  1  one-cycle pulse; ignored while busy
- base_addr  in  32  first word address; bits [1:0] ignored
- word_count  in  16  words to fetch
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky bus error, cleared by next accepted start
- pix_data  out  32  FIFO head word
- pix_valid  out  1  FIFO non-empty
- pix_ready  in  1  sink accepts pix_data when pix_valid & pix_ready

## Operation
- Reset values: HADDR=0, HTRANS=IDLE, busy=0, done=0, err=0, pix_valid=0, pix_data=0, FIFO empty, state IDLE.
- States: IDLE, RUN, DRAIN, ERR.
- IDLE: start accepted → latch addr={base_addr[31:2],2'b00}, remaining=word_count, err←0, busy←1. word_count=0 → no bus traffic, done pulses one cycle after start, back to IDLE.
- RUN: when HREADY=1 and remaining>0 and (fifo_count + inflight + 1) ≤ FIFO_DEPTH, register HTRANS=NONSEQ, HADDR=addr; addr+=4 (wraps mod 2^32), remaining−=1. Otherwise register HTRANS=IDLE when HREADY=1. inflight = 1 while a NONSEQ data phase is pending.
- HADDR/HTRANS change only on cycles with HREADY=1 (held through wait states).
- Data phase completes on HREADY=1 & HRESP=0: HRDATA pushed into FIFO that edge.
- remaining reaches 0 → DRAIN; DRAIN waits for last data phase to complete, then done pulses, busy←0, IDLE. FIFO may still hold words; sink drains them independently.
- Error: HRESP=1 & HREADY=0 (first error cycle) → register HTRANS=IDLE (cancels any pending address phase), discard remaining count, go ERR. ERR on HREADY=1 → err←1, done pulse, busy←0, IDLE. Errored word not pushed.
- FIFO: push and pop same cycle allowed at any occupancy; push never occurs when full (guaranteed by credit rule). pix_data holds head; unchanged while pix_valid & !pix_ready.
- start while busy: ignored, no effect on any counter.

## Timing
- start sampled at edge 0 → NONSEQ visible cycle 1 → data phase cycle 2 (zero wait) → word in FIFO at edge 3, pix_valid=1 cycle 3.
- Zero wait states, pix_ready=1: one word per cycle sustained; N words complete with done high cycle N+2.
- Each HREADY=0 cycle extends the current data phase by one cycle.
- done is registered, exactly one cycle wide; busy falls same edge done rises.
- Pixel sink stalled: at most FIFO_DEPTH words accepted, then HTRANS=IDLE until space frees.

## Test plan
- base_addr=0x2000_0000, word_count=4, zero-wait memory, pix_ready=1 → HADDR 0x2000_0000..0x2000_000C on cycles 1-4, pix_data sequence matches memory, done at cycle 6, err=0.
- word_count=8, pix_ready=0 → exactly 4 NONSEQ issued then IDLE; raise pix_ready → remaining 4 fetched, 8 words delivered in order.
- Random HREADY=0 insertion (30%) on 16-word fetch → HADDR/HTRANS stable during every wait cycle, data intact.
- HRESP two-cycle error on 3rd word of 6 → HTRANS=IDLE in second error cycle, no further NONSEQ, err=1, done pulse, only words 1-2 in FIFO.
- word_count=0 → no NONSEQ, done one cycle after start; start during busy → ignored.
- base_addr=0xFFFF_FFF8, word_count=3 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; HRESETn low mid-fetch → all outputs at reset values immediately.

Source files
------------

// File: rtl/ahblite_lcd_fetch.sv
// ahblite_lcd_fetch: AHB-Lite read master streaming a frame-buffer block into a pixel FIFO
// Ports:
//   HCLK, HRESETn                 clock (rising edge) and asynchronous active-low reset
//   HADDR..HWDATA                 AHB-Lite master outputs (single-word reads only)
//   HREADY, HRDATA, HRESP         AHB-Lite slave responses
//   start, base_addr, word_count  launch a fetch of word_count words from base_addr
//   busy, done, err               fetch in progress, completion pulse, sticky bus error
//   pix_data, pix_valid, pix_ready  valid/ready stream of fetched words
module ahblite_lcd_fetch #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;
    state_t        r_state;
    logic [31:0]   r_addr;
    logic [15:0]   r_rem;
    logic          r_dph;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    logic          w_credit;
    logic          w_issue;
    logic          w_err;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HWRITE    = 1'b0;
    assign HWDATA    = '0;
    assign w_push    = HREADY & r_dph & ~HRESP;
    assign w_pop     = pix_valid & pix_ready;
    // A new transfer needs a guaranteed FIFO slot: count stored words, the data phase in
    // flight, the address phase on the bus, and the new word; a same-edge pop frees one.
    assign w_credit  = (AW+2)'(r_cnt) + (AW+2)'(HTRANS[1]) + (AW+2)'(r_dph) + (AW+2)'(1)
                       <= (AW+2)'(FIFO_DEPTH) + (AW+2)'(w_pop);
    assign w_issue   = HREADY & (r_state == S_RUN) & (r_rem != '0) & w_credit;
    // First ERROR cycle (HREADY low) of a data phase aborts the fetch.
    assign w_err     = r_dph & HRESP & ~HREADY & ((r_state == S_RUN) | (r_state == S_DRAIN));
    assign pix_valid = r_cnt != '0;
    assign pix_data  = r_mem[r_rp];
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_dph   <= 1'b0;
            HADDR   <= '0;
            HTRANS  <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            // The error cancels a pending address phase even though HREADY is low.
            if (w_err) begin
                HTRANS <= 2'b00;
            end else if (HREADY) begin
                HTRANS <= w_issue ? 2'b10 : 2'b00;
                r_dph  <= HTRANS[1];
                if (w_issue) HADDR <= r_addr;
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_addr  <= base_addr & 32'hFFFF_FFFC;
                    r_rem   <= word_count;
                    err     <= 1'b0;
                    busy    <= 1'b1;
                    r_state <= (word_count == '0) ? S_DRAIN : S_RUN;
                end
                S_RUN: if (w_err) begin
                    r_rem   <= '0;
                    r_state <= S_ERR;
                end else if (w_issue) begin
                    r_addr <= r_addr + 32'd4;
                    r_rem  <= r_rem - 16'd1;
                    if (r_rem == 16'd1) r_state <= S_DRAIN;
                end
                S_DRAIN: if (w_err) begin
                    r_state <= S_ERR;
                end else if (!HTRANS[1] && (HREADY || !r_dph)) begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: if (HREADY) begin
                    err     <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= HRDATA;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_ahblite_lcd_fetch.sv
// tb_ahblite_lcd_fetch: randomized scoreboard bench for ahblite_lcd_fetch
module tb_ahblite_lcd_fetch;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    always #5 HCLK = ~HCLK;

    ahblite_lcd_fetch dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HRESP(HRESP), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .err(err), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_pix[$];
    int          n_acc = 0;
    bit          wait_en = 0;
    bit          err_en = 0;
    logic [31:0] err_addr = '0;
    int          ready_mode = 1;
    logic        p_ready, p_resp, s_dph, q_valid, q_ready;
    logic [1:0]  p_ht;
    logic [31:0] p_addr, s_daddr, q_data;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[7:0], a[31:8]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
        chk({tag, "_haddr"}, HADDR, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_pvalid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pdata"}, pix_data, 32'd0);
        chk({tag, "_consts"}, {17'd0, HSIZE, HBURST, HPROT, HWRITE, HWDATA[3:0]}, {17'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 4'd0});
    endtask

    // AHB slave + pixel sink + scoreboard monitors, all evaluated at the falling edge.
    initial begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; pix_ready = 1'b0;
        p_ready = 1'b1; p_resp = 1'b0; p_ht = 2'b00; p_addr = '0; s_dph = 1'b0; s_daddr = '0;
        q_valid = 1'b0; q_ready = 1'b0; q_data = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                s_dph = 1'b0; p_ready = 1'b1; p_resp = 1'b0; p_ht = 2'b00;
                HREADY = 1'b1; HRESP = 1'b0; pix_ready = 1'b0; q_valid = 1'b0;
            end else begin
                if (p_ready) begin
                    s_dph = p_ht[1];
                    s_daddr = p_addr;
                    if (p_ht[1]) begin
                        n_acc++;
                        if (exp_addr.size() == 0) begin
                            n_vec++; n_bad++;
                            $display("FAIL addr_extra: got NONSEQ to %h want none", p_addr);
                        end else chk("addr", p_addr, exp_addr.pop_front());
                    end
                end else if (!p_resp) begin
                    chk("wait_htrans", 32'(HTRANS), 32'(p_ht));
                    if (p_ht[1]) chk("wait_haddr", HADDR, p_addr);
                end else chk("err_cancel", 32'(HTRANS), 32'd0);
                if (p_resp && !p_ready) begin
                    HREADY = 1'b1; HRESP = 1'b1;
                end else if (s_dph && err_en && s_daddr == err_addr) begin
                    HREADY = 1'b0; HRESP = 1'b1;
                end else begin
                    HRESP = 1'b0;
                    HREADY = !(s_dph && wait_en && $urandom_range(0, 9) < 3);
                end
                HRDATA = s_dph ? memw(s_daddr) : $urandom;
                p_ready = HREADY; p_resp = HRESP; p_ht = HTRANS; p_addr = HADDR;
                if (q_valid && !q_ready) begin
                    chk("pix_hold_valid", 32'(pix_valid), 32'd1);
                    chk("pix_hold_data", pix_data, q_data);
                end
                pix_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
                if (pix_valid && pix_ready) begin
                    if (exp_pix.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL pix_extra: got %h want none", pix_data);
                    end else chk("pix", pix_data, exp_pix.pop_front());
                end
                q_valid = pix_valid; q_ready = pix_ready; q_data = pix_data;
            end
        end
    end

    // Reference model: a fetch reads consecutive aligned words; an error on word err_at
    // means words 0..err_at are addressed but only 0..err_at-1 are delivered.
    task automatic launch(input logic [31:0] base, input int cnt, input int err_at);
        logic [31:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            if (err_at < 0 || i <= err_at) exp_addr.push_back(a);
            if (err_at < 0 || i < err_at) exp_pix.push_back(memw(a));
        end
        n_acc = 0;
        @(negedge HCLK);
        base_addr = base; word_count = 16'(cnt); start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
    endtask

    task automatic run(input logic [31:0] base, input int cnt, input int err_at, input int rmode,
                       input int exp_done, input int poke, input bit stall, input bit exp_err);
        int cyc = 0;
        int first_ns = -1;
        int k = 0;
        ready_mode = rmode;
        launch(base, cnt, err_at);
        chk("busy_start", 32'(busy), 32'd1);
        chk("err_start", 32'(err), 32'd0);
        if (stall) begin
            repeat (20) @(negedge HCLK);
            cyc = 20;
            chk("stall_acc", 32'(n_acc), 32'd4);
            chk("stall_idle", 32'(HTRANS), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            ready_mode = 1;
        end
        while (!done && cyc < 3000) begin
            if (HTRANS == 2'b10 && first_ns < 0) first_ns = cyc;
            if (cyc == poke) begin start = 1'b1; base_addr = 32'h1234_5678; word_count = 16'd99; end
            if (cyc == poke + 1) start = 1'b0;
            @(negedge HCLK);
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL done_timeout: got no done after %0d cycles want done", cyc);
        end else begin
            if (exp_done >= 0) begin
                chk("done_cyc", 32'(cyc), 32'(exp_done));
                chk("first_nonseq", 32'(first_ns), (cnt > 0) ? 32'd1 : 32'hFFFF_FFFF);
            end
            chk("busy_done", 32'(busy), 32'd0);
            chk("err_done", 32'(err), 32'(exp_err));
        end
        @(negedge HCLK);
        chk("done_pulse", 32'(done), 32'd0);
        ready_mode = 1;
        while ((exp_pix.size() > 0 || pix_valid) && k < 200) begin
            @(negedge HCLK);
            k++;
        end
        chk("pix_left", 32'(exp_pix.size()), 32'd0);
        chk("addr_left", 32'(exp_addr.size()), 32'd0);
        chk("accepted", 32'(n_acc), 32'((err_at < 0) ? cnt : err_at + 1));
    endtask

    initial begin
        HRESETn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        repeat (3) @(negedge HCLK);
        chk_reset("reset");
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        run(32'h2000_0000, 4, -1, 1, 6, -1, 0, 0);
        run(32'h3000_0100, 8, -1, 0, -1, -1, 1, 0);
        wait_en = 1;
        run(32'h4000_0040, 16, -1, 1, -1, -1, 0, 0);
        for (int t = 0; t < 3; t++) run($urandom, int'($urandom_range(1, 20)), -1, 2, -1, -1, 0, 0);
        wait_en = 0;
        err_en = 1; err_addr = 32'h5000_0008;
        run(32'h5000_0000, 6, 2, 0, 6, -1, 0, 1);
        err_en = 0;
        run(32'h6000_0000, 0, -1, 1, 1, -1, 0, 0);
        run(32'h7000_0010, 4, -1, 1, 6, 2, 0, 0);
        run(32'hFFFF_FFF8, 3, -1, 1, 5, -1, 0, 0);
        ready_mode = 0;
        launch(32'h8000_0000, 10, -1);
        repeat (4) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        chk_reset("midreset");
        exp_addr.delete();
        exp_pix.delete();
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        run(32'h9000_0003, 2, -1, 1, 4, -1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
